// File: rtl/ram_stream_writer_if.sv
// ram_stream_writer_if: byte stream into, and single-port RAM port out of, ram_stream_writer
interface ram_stream_writer_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
);
    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic              s_ready;
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din;
    logic [DATA_W-1:0] ram_dout;
    modport master (
        input  s_valid, s_data, ram_dout,
        output s_ready, ram_en, ram_we, ram_addr, ram_din
    );
    modport slave (
        output s_valid, s_data, ram_dout,
        input  s_ready, ram_en, ram_we, ram_addr, ram_din
    );
endinterface

// File: rtl/ram_stream_writer.sv
// ram_stream_writer: loads DEPTH stream words into a block RAM from BASE_ADDR; VERIFY_EN adds a readback checksum pass
module ram_stream_writer #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 5,
    parameter int DEPTH     = 32,
    parameter int BASE_ADDR = 0
) (
    input  logic                clock,
    input  logic                rst_n,
    input  logic                start,
    ram_stream_writer_if.master bus,
    output logic                busy,
    output logic                done,
    output logic [ADDR_W:0]     wr_count,
    output logic                verify_ok
);
    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   CNT_LAST = (ADDR_W+1)'(DEPTH - 1);
    typedef enum logic [2:0] {IDLE, WRITE, FLUSH, VRD, VWAIT, DONE} state_t;
    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [15:0]       wsum;
    logic              hs;
    // s_ready is only ever high in WRITE, so it alone qualifies the handshake
    assign hs = bus.s_valid & bus.s_ready;
`ifdef VERIFY_EN
    localparam logic [ADDR_W:0] CNT_DEPTH = (ADDR_W+1)'(DEPTH);
    logic [ADDR_W:0]   rcnt;
    logic [ADDR_W-1:0] raddr;
    logic [15:0]       rsum;
    logic [15:0]       rsum_nx;
    logic              rv;
    // rv marks the cycle after a read strobe, when douta holds that word
    assign rsum_nx = rsum + (rv ? 16'(bus.ram_dout) : 16'd0);
`else
    logic unused;
    assign unused = ^bus.ram_dout;
`endif
    // load sequencer: every output is registered here
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            addr         <= '0;
            wsum         <= '0;
            wr_count     <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            verify_ok    <= 1'b0;
            bus.s_ready  <= 1'b0;
            bus.ram_en   <= 1'b0;
            bus.ram_we   <= 1'b0;
            bus.ram_addr <= '0;
            bus.ram_din  <= '0;
`ifdef VERIFY_EN
            rcnt         <= '0;
            raddr        <= '0;
            rsum         <= '0;
            rv           <= 1'b0;
`endif
        end else begin
            done       <= 1'b0;
            bus.ram_en <= 1'b0;
            bus.ram_we <= 1'b0;
`ifdef VERIFY_EN
            rv         <= bus.ram_en & ~bus.ram_we;
            rsum       <= rsum_nx;
`endif
            case (state)
                IDLE: if (start) begin
                    state       <= WRITE;
                    addr        <= BASE;
                    wr_count    <= '0;
                    wsum        <= '0;
                    verify_ok   <= 1'b0;
                    busy        <= 1'b1;
                    bus.s_ready <= 1'b1;
`ifdef VERIFY_EN
                    rsum        <= '0;
`endif
                end
                WRITE: if (hs) begin
                    bus.ram_en   <= 1'b1;
                    bus.ram_we   <= 1'b1;
                    bus.ram_addr <= addr;
                    bus.ram_din  <= bus.s_data;
                    addr         <= addr + ADDR_W'(1);
                    wr_count     <= wr_count + (ADDR_W+1)'(1);
                    wsum         <= wsum + 16'(bus.s_data);
                    if (wr_count == CNT_LAST) begin
                        state       <= FLUSH;
                        bus.s_ready <= 1'b0;
                    end
                end
`ifdef VERIFY_EN
                FLUSH: begin
                    state        <= VRD;
                    bus.ram_en   <= 1'b1;
                    bus.ram_addr <= BASE;
                    raddr        <= BASE + ADDR_W'(1);
                    rcnt         <= (ADDR_W+1)'(1);
                end
                VRD: if (rcnt == CNT_DEPTH) state <= VWAIT;
                else begin
                    bus.ram_en   <= 1'b1;
                    bus.ram_addr <= raddr;
                    raddr        <= raddr + ADDR_W'(1);
                    rcnt         <= rcnt + (ADDR_W+1)'(1);
                end
                VWAIT: begin
                    state     <= DONE;
                    busy      <= 1'b0;
                    done      <= 1'b1;
                    verify_ok <= rsum_nx == wsum;
                end
`else
                FLUSH: begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
`endif
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
